alu_core: RTL and testbench



---
 rtl/alu_core.sv | 160 ++++++++++++++++
 tb/tb_alu_core.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: execute-stage ALU of the 16-bit, 4-phase multicycle CPU.
// Decodes the instruction word and combines sr1/sr2, the immediate fields and
// pc into one 16-bit result. The result is captured on the execute-phase edge.
// It is either the register write-back value or, for branches, the next pc.
`timescale 1ns/1ps

module alu_core (
  input  logic        CLK,
  input  logic        RSTN,
  output logic [15:0] q,
  input  logic [15:0] sr1,
  input  logic [15:0] sr2,
  input  logic [15:0] pc,
  input  logic [15:0] ir,
  input  logic [3:0]  ph
);

  // Instruction classes, ir[15:14]
  localparam logic [1:0] CLS_RTYPE  = 2'b00;
  localparam logic [1:0] CLS_IMM    = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;
  localparam logic [1:0] CLS_MEM    = 2'b11;

  // R-type function codes, ir[4:0]
  localparam logic [4:0] FN_MOV = 5'b00000;
  localparam logic [4:0] FN_NOT = 5'b00001;
  localparam logic [4:0] FN_ADD = 5'b00010;
  localparam logic [4:0] FN_SUB = 5'b00011;
  localparam logic [4:0] FN_AND = 5'b00100;
  localparam logic [4:0] FN_OR  = 5'b00101;
  localparam logic [4:0] FN_XOR = 5'b00110;
  localparam logic [4:0] FN_SLL = 5'b00111;
  localparam logic [4:0] FN_SRL = 5'b01000;
  localparam logic [4:0] FN_SRA = 5'b01001;

  // Branch conditions, ir[13:11]; 101..111 are never taken
  localparam logic [2:0] CC_ALWAYS = 3'b000;
  localparam logic [2:0] CC_NZ     = 3'b001;
  localparam logic [2:0] CC_Z      = 3'b010;
  localparam logic [2:0] CC_NEG    = 3'b011;
  localparam logic [2:0] CC_POS    = 3'b100;

  // Decoded instruction fields
  logic [1:0]  cls;
  logic [4:0]  func;
  logic [2:0]  cond;
  logic [2:0]  dst_sel;
  logic [15:0] simm8;
  logic [15:0] simm5;

  // Datapath intermediates
  logic [3:0]  shamt;
  logic [15:0] sll_res;
  logic [15:0] srl_res;
  logic [15:0] sra_res;
  logic [15:0] add_res;
  logic [15:0] sub_res;
  logic [15:0] rtype_res;
  logic [15:0] imm_res;
  logic        taken;
  logic [15:0] branch_res;
  logic [15:0] mem_res;
  logic [15:0] result_next;

  // Only the execute phase moves q; the other phase bits are informational here.
  logic unused_ph;
  assign unused_ph = ^{ph[3], ph[1:0]};

  // Split the instruction word into its fields and sign-extend the immediates
  always_comb begin
    cls     = ir[15:14];
    func    = ir[4:0];
    cond    = ir[13:11];
    dst_sel = ir[10:8];
    simm8   = {{8{ir[7]}}, ir[7:0]};
    simm5   = {{11{ir[4]}}, ir[4:0]};
  end

  // Barrel shifts of sr1 by the low nibble of sr2; SRA replicates the sign bit
  always_comb begin
    shamt   = sr2[3:0];
    sll_res = sr1 << shamt;
    srl_res = sr1 >> shamt;
    sra_res = $unsigned($signed(sr1) >>> shamt);
  end

  // Shared adder/subtractor, all modulo 2^16 with carries discarded
  always_comb begin
    add_res = sr1 + sr2;
    sub_res = sr1 - sr2;
  end

  // R-type function select; unassigned codes produce zero
  always_comb begin
    rtype_res = 16'h0000;
    case (func)
      FN_MOV:  rtype_res = sr2;
      FN_NOT:  rtype_res = ~sr2;
      FN_ADD:  rtype_res = add_res;
      FN_SUB:  rtype_res = sub_res;
      FN_AND:  rtype_res = sr1 & sr2;
      FN_OR:   rtype_res = sr1 | sr2;
      FN_XOR:  rtype_res = sr1 ^ sr2;
      FN_SLL:  rtype_res = sll_res;
      FN_SRL:  rtype_res = srl_res;
      FN_SRA:  rtype_res = sra_res;
      default: rtype_res = 16'h0000;
    endcase
  end

  // Immediate class: a zero destination field means load-immediate, else add-immediate
  always_comb begin
    if (dst_sel == 3'b000) begin
      imm_res = simm8;
    end else begin
      imm_res = sr1 + simm8;
    end
  end

  // Branch condition evaluated on sr1, then pick target or fall-through pc
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_ALWAYS: taken = 1'b1;
      CC_NZ:     taken = (sr1 != 16'h0000);
      CC_Z:      taken = (sr1 == 16'h0000);
      CC_NEG:    taken = sr1[15];
      CC_POS:    taken = ~sr1[15];
      default:   taken = 1'b0;
    endcase
    branch_res = taken ? (pc + simm8) : pc;
  end

  // Memory class computes an effective address from a 5-bit signed offset
  always_comb begin
    mem_res = sr1 + simm5;
  end

  // Final result mux by instruction class
  always_comb begin
    result_next = 16'h0000;
    case (cls)
      CLS_RTYPE:  result_next = rtype_res;
      CLS_IMM:    result_next = imm_res;
      CLS_BRANCH: result_next = branch_res;
      CLS_MEM:    result_next = mem_res;
      default:    result_next = 16'h0000;
    endcase
  end

  // Result register: cleared asynchronously, loaded only on the execute-phase edge
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      q <= 16'h0000;
    end else if (ph[2]) begin
      q <= result_next;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed bench for alu_core. Each instruction is walked through
// the four phases; the expected result is queued when execute is driven and
// popped and compared during write-back. Hold behaviour is checked at the
// fetch, operand-read and write-back edges.
`timescale 1ns/1ps

module tb_alu_core;

  logic        CLK;
  logic        RSTN;
  logic [15:0] q;
  logic [15:0] sr1;
  logic [15:0] sr2;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [3:0]  ph;

  int          n_checks;
  int          n_fails;
  logic [15:0] last_q;
  logic [15:0] sb_q[$];

  alu_core dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .q    (q),
    .sr1  (sr1),
    .sr2  (sr2),
    .pc   (pc),
    .ir   (ir),
    .ph   (ph)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [15:0] exp);
    n_checks++;
    assert (q === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, q, exp);
    end
  endtask

  // One full fetch/read/execute/write-back cycle for a single instruction
  task automatic run_instr(input string tag, input logic [15:0] i_ir,
                           input logic [15:0] i_sr1, input logic [15:0] i_sr2,
                           input logic [15:0] i_pc, input logic [15:0] exp);
    logic [15:0] got_exp;
    // fetch: junk on every operand must not disturb q
    @(negedge CLK);
    ph  = 4'b0001;
    ir  = 16'($urandom);
    sr1 = 16'($urandom);
    sr2 = 16'($urandom);
    pc  = 16'($urandom);
    @(posedge CLK);
    // operand read
    @(negedge CLK);
    check({tag, "_hold_ph0"}, last_q);
    ph  = 4'b0010;
    ir  = i_ir;
    sr1 = i_sr1;
    sr2 = i_sr2;
    pc  = i_pc;
    @(posedge CLK);
    // execute
    @(negedge CLK);
    check({tag, "_hold_ph1"}, last_q);
    ph = 4'b0100;
    sb_q.push_back(exp);
    @(posedge CLK);
    // write-back
    @(negedge CLK);
    ph = 4'b1000;
    ir = 16'($urandom);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
      got_exp = 16'h0000;
    end else begin
      got_exp = sb_q.pop_front();
      check(tag, got_exp);
    end
    $display("%s ir=%h sr1=%h sr2=%h pc=%h q=%h exp=%h", tag, i_ir, i_sr1, i_sr2, i_pc, q, got_exp);
    last_q = got_exp;
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_hold_ph3"}, last_q);
    ph = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    last_q   = 16'h0000;
    RSTN = 1'b0;
    ph   = 4'b0000;
    ir   = 16'h0000;
    sr1  = 16'h0000;
    sr2  = 16'h0000;
    pc   = 16'h0000;

    // 1. reset pulse, q held at zero even with an execute phase under reset
    #3 RSTN = 1'b1;
    #1 check("reset_assert", 16'h0000);
    @(negedge CLK);
    ph = 4'b0100;
    ir = 16'h7064;
    @(posedge CLK);
    @(negedge CLK);
    check("reset_held", 16'h0000);
    RSTN = 1'b0;
    ph   = 4'b0000;
    last_q = 16'h0000;

    run_instr("li_neg50", 16'h78CE, 16'h0000, 16'h0000, 16'h0000, 16'hFFCE);
    run_instr("li_100",   16'h7064, 16'h0000, 16'h0000, 16'h0000, 16'h0064);

    // 2. ADD loop
    run_instr("add_loop1", 16'h37C2, 16'hFFCE, 16'h0064, 16'h0000, 16'h0032);
    run_instr("add_loop2", 16'h37C2, 16'hFFCE, 16'h0032, 16'h0000, 16'h0000);

    // 3. BNZ taken and fall-through
    run_instr("bnz_taken", 16'h8EFE, 16'h0032, 16'h0000, 16'h0004, 16'h0002);
    run_instr("bnz_fall",  16'h8EFE, 16'h0000, 16'h0000, 16'h0004, 16'h0004);

    // 4. unconditional branch, then LI
    run_instr("br_always", 16'h80FC, 16'h1234, 16'h0000, 16'h0005, 16'h0001);
    run_instr("li_r4_89",  16'h6059, 16'h0000, 16'h0000, 16'h0000, 16'h0059);

    // 5. arithmetic and shifts
    run_instr("sub_wrap",  16'h0003, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF);
    run_instr("add_ovf",   16'h0002, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000);
    run_instr("sra_15",    16'h0009, 16'h8000, 16'h000F, 16'h0000, 16'hFFFF);
    run_instr("sll_15",    16'h0007, 16'h0001, 16'h000F, 16'h0000, 16'h8000);
    run_instr("srl_15",    16'h0008, 16'h8000, 16'h000F, 16'h0000, 16'h0001);
    run_instr("sll_by0",   16'h0007, 16'h1234, 16'h0010, 16'h0000, 16'h1234);
    run_instr("fn_unk",    16'h001F, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
    run_instr("fn_unk0a",  16'h000A, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
    run_instr("mov",       16'h0000, 16'hAAAA, 16'h5A5A, 16'h0000, 16'h5A5A);
    run_instr("not",       16'h0001, 16'h0000, 16'h00FF, 16'h0000, 16'hFF00);
    run_instr("and",       16'h0004, 16'hF0F0, 16'hFF00, 16'h0000, 16'hF000);
    run_instr("or",        16'h0005, 16'hF0F0, 16'hFF00, 16'h0000, 16'hFFF0);
    run_instr("xor",       16'h0006, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0FF0);
    run_instr("addi_m128", 16'h4180, 16'h0100, 16'h0000, 16'h0000, 16'h0080);
    run_instr("mem_m1",    16'hC0FF, 16'h0010, 16'h0000, 16'h0000, 16'h000F);
    run_instr("br_never",  16'hA804, 16'h0000, 16'h0000, 16'h0010, 16'h0010);
    run_instr("bz_taken",  16'h9004, 16'h0000, 16'h0000, 16'h0010, 16'h0014);
    run_instr("bmi_taken", 16'h9880, 16'h8000, 16'h0000, 16'h0100, 16'h0080);
    run_instr("bpl_fall",  16'hA010, 16'h8000, 16'h0000, 16'h0100, 16'h0100);

    // 6. hold under ph=0000 and a non-one-hot phase without bit 2
    @(negedge CLK);
    ph = 4'b0000;
    ir = 16'h7064;
    @(posedge CLK);
    @(negedge CLK);
    check("hold_ph_zero", last_q);
    ph = 4'b1011;
    @(posedge CLK);
    @(negedge CLK);
    check("hold_ph_1011", last_q);
    ph = 4'b0000;

    // 6. async reset between edges, then recovery at the next execute edge
    run_instr("li_pre_rst", 16'h6059, 16'h0000, 16'h0000, 16'h0000, 16'h0059);
    #2 RSTN = 1'b1;
    #1 check("async_clear", 16'h0000);
    @(negedge CLK);
    RSTN   = 1'b0;
    last_q = 16'h0000;
    run_instr("post_rst", 16'h78CE, 16'h0000, 16'h0000, 16'h0000, 16'hFFCE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
